// File: rtl/hack_soc_pkg.sv
// Shared Hack SoC definitions used by the VRAM access arbiter.
// Contents:
//   SRAM_ADDR_WIDTH  word address width of the 23LC1024 serial SRAM
//   HACK_DATA_WIDTH  Hack machine word width
//   arb_state_t      arbiter FSM state encoding
//   arb_ch_t         requester channel IDs (display = 0, CPU = 1)
package hack_soc_pkg;

  localparam int SRAM_ADDR_WIDTH = 17;
  localparam int HACK_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    CH_DISP = 1'b0,
    CH_CPU  = 1'b1
  } arb_ch_t;

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Command/response bus between the VRAM arbiter and the QSPI SRAM controller.
// Signals:
//   mem_start  1-cycle command strobe (arbiter -> controller)
//   mem_we     command write flag
//   mem_addr   command word address
//   mem_wdata  command write data
//   mem_busy   controller cannot accept a command (controller -> arbiter)
//   mem_done   1-cycle completion pulse, mem_rdata valid
//   mem_rdata  read data
// Modports: master = arbiter side, slave = controller side.
interface vram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
);

  logic                  mem_start;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_busy;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_start, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_done, mem_rdata
  );

  modport slave (
    input  mem_start, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_done, mem_rdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive display grants taken while the CPU waits.
// Ports:
//   clk       clock
//   reset     synchronous, active-high
//   inc       count one more display grant (saturates at LIMIT)
//   clr       restart the count (wins over inc)
//   at_limit  count has reached LIMIT; the CPU must win the next arbitration
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] count;

  // Count display wins; hold at the limit so the guard stays armed until the CPU is served
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == CW'(LIMIT));

endmodule

// File: rtl/vram_access_arbiter.sv
// Shares one QSPI serial-SRAM controller between the display line fetcher
// (ch0, read-only, fixed priority) and the Hack CPU screen path (ch1, read/write).
// One command is in flight at a time; a starvation guard lets the CPU in after
// STARVE_LIMIT back-to-back display grants, and a watchdog aborts a command whose
// mem_done never arrives (owner still gets done, with rdata forced to 0).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   disp_req/disp_addr                  display read request (held until disp_done)
//   disp_done/disp_rdata                display completion pulse and read data
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request (held until cpu_done)
//   cpu_done/cpu_rdata                  CPU completion pulse and read data
//   mem                                 controller command/response bus (master side)
//   arb_busy                            FSM is not IDLE
//   arb_timeout                         sticky watchdog abort flag
module vram_access_arbiter
  import hack_soc_pkg::*;
#(
  parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = HACK_DATA_WIDTH,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_done,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  vram_access_arbiter_if.master mem,
  output logic                  arb_busy,
  output logic                  arb_timeout
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t            state;
  arb_state_t            state_next;
  arb_ch_t               owner;
  logic                  start_pulse;
  logic                  grant_cpu;
  logic                  grant_disp;
  logic                  starve_at_limit;
  logic                  timeout_hit;
  logic [WD_W-1:0]       wdog;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] disp_rdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  timeout_q;

  // Arbitration only happens in IDLE; the CPU wins when the display is quiet or
  // when the display has used up its allowance of consecutive grants
  assign grant_cpu  = (state == ARB_IDLE) && cpu_req && (!disp_req || starve_at_limit);
  assign grant_disp = (state == ARB_IDLE) && disp_req && !grant_cpu;

  // Display grants taken over a waiting CPU accumulate; any other grant restarts the count
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (grant_disp && cpu_req),
    .clr     (grant_cpu || (grant_disp && !cpu_req)),
    .at_limit(starve_at_limit)
  );

  // A disabled watchdog (TIMEOUT_CYCLES = 0) never fires
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the command strobe; the strobe is held back while the
  // controller reports busy and fires in the cycle busy drops
  always_comb begin
    state_next  = state;
    start_pulse = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_cpu || grant_disp) begin
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (!mem.mem_busy) begin
          start_pulse = 1'b1;
          state_next  = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem.mem_done || timeout_hit) begin
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Command latch at grant, response capture in WAIT, watchdog and sticky timeout flag.
  // A real mem_done takes precedence over a watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= CH_DISP;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      disp_rdata_q <= '0;
      cpu_rdata_q  <= '0;
      timeout_q    <= 1'b0;
      wdog         <= '0;
    end else begin
      if (grant_cpu) begin
        owner     <= CH_CPU;
        cmd_we    <= cpu_we;
        cmd_addr  <= cpu_addr;
        cmd_wdata <= cpu_wdata;
      end else if (grant_disp) begin
        owner     <= CH_DISP;
        cmd_we    <= 1'b0;
        cmd_addr  <= disp_addr;
        cmd_wdata <= '0;
      end

      if (state == ARB_WAIT) begin
        wdog <= wdog + 1'b1;
        if (mem.mem_done) begin
          if (owner == CH_CPU) begin
            cpu_rdata_q <= mem.mem_rdata;
          end else begin
            disp_rdata_q <= mem.mem_rdata;
          end
        end else if (timeout_hit) begin
          timeout_q <= 1'b1;
          if (owner == CH_CPU) begin
            cpu_rdata_q <= '0;
          end else begin
            disp_rdata_q <= '0;
          end
        end
      end else begin
        wdog <= '0;
      end
    end
  end

  assign mem.mem_start = start_pulse;
  assign mem.mem_we    = cmd_we;
  assign mem.mem_addr  = cmd_addr;
  assign mem.mem_wdata = cmd_wdata;

  assign disp_done   = (state == ARB_RESP) && (owner == CH_DISP);
  assign cpu_done    = (state == ARB_RESP) && (owner == CH_CPU);
  assign disp_rdata  = disp_rdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign arb_busy    = (state != ARB_IDLE);
  assign arb_timeout = timeout_q;

endmodule
